// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: state encodings, request codes and sizing helper for the pc sequencer.
package pc_ctrl_pkg;
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;
  localparam logic [2:0] REQ_NONE = 3'd0;
  localparam logic [2:0] REQ_HALT = 3'd1;
  localparam logic [2:0] REQ_RET  = 3'd2;
  localparam logic [2:0] REQ_CALL = 3'd3;
  localparam logic [2:0] REQ_JMP  = 3'd4;
  localparam logic [2:0] REQ_JZ   = 3'd5;
  localparam logic [2:0] REQ_JNZ  = 3'd6;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses; sp counts occupancy, entry sp-1 is the top.
module ret_stack import pc_ctrl_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SPW   = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [SPW-1:0]   sp,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  assign full  = sp_q == SPW'(DEPTH);
  assign empty = sp_q == '0;
  assign sp    = sp_q;
  assign sp_d  = (push && !full) ? sp_q + SPW'(1) : (pop && !empty) ? sp_q - SPW'(1) : sp_q;
  // Compare-based selection keeps index widths exact for any DEPTH.
  always_comb begin
    dout = '0;
    for (int k = 0; k < DEPTH; k++)
      if (sp_q == SPW'(k + 1)) dout = mem_q[k];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sp_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      sp_q <= sp_d;
      if (push && !full)
        for (int k = 0; k < DEPTH; k++)
          if (sp_q == SPW'(k)) mem_q[k] <= din;
    end
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: next-address sequencer for the pc; Mealy load strobe/address,
// return-address stack and boot/run/halt/fault state machine.
module pc_ctrl import pc_ctrl_pkg::*; #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             pc_in,
  input  logic [WIDTH-1:0]             target,
  input  logic                         jmp,
  input  logic                         jz,
  input  logic                         jnz,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         halt,
  input  logic                         run,
  input  logic                         zero_flag,
  output logic                         pc_ld,
  output logic [WIDTH-1:0]             pc_addr,
  output logic                         halted,
  output logic                         fault,
  output logic                         stk_ovf,
  output logic                         stk_unf,
  output logic [clog2(DEPTH+1)-1:0]    sp
);
  logic [1:0]       state_q, state_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [2:0]       req;
  logic             in_run, push, pop, full, empty;
  logic [WIDTH-1:0] top;
  assign req = halt ? REQ_HALT : ret ? REQ_RET : call ? REQ_CALL : jmp ? REQ_JMP :
               jz ? REQ_JZ : jnz ? REQ_JNZ : REQ_NONE;
  assign in_run  = state_q == ST_RUN;
  assign push    = in_run && req == REQ_CALL && !full;
  assign pop     = in_run && req == REQ_RET && !empty;
  assign halted  = state_q == ST_HALT;
  assign fault   = state_q == ST_FAULT;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;
  ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk(clk), .rst_n(rst), .push(push), .pop(pop), .din(pc_in + WIDTH'(1)),
    .dout(top), .sp(sp), .full(full), .empty(empty)
  );
  // Default is "reload own value"; only the increment cases drop pc_ld.
  always_comb begin
    pc_ld   = 1'b1;
    pc_addr = pc_in;
    state_d = state_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      ST_BOOT: begin
        pc_addr = RESET_VEC;
        state_d = ST_RUN;
      end
      ST_HALT: if (run) begin
        pc_ld   = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: case (req)
        REQ_HALT: state_d = ST_HALT;
        REQ_RET: if (empty) begin
          unf_d   = 1'b1;
          state_d = ST_FAULT;
        end else pc_addr = top;
        REQ_CALL: if (full) begin
          ovf_d   = 1'b1;
          state_d = ST_FAULT;
        end else pc_addr = target;
        REQ_JMP: pc_addr = target;
        REQ_JZ: begin
          pc_ld   = zero_flag;
          pc_addr = target;
        end
        REQ_JNZ: begin
          pc_ld   = !zero_flag;
          pc_addr = target;
        end
        default: pc_ld = 1'b0;
      endcase
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_BOOT;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: drives pc_ctrl with a pc register, directed scenarios and random traffic vs. a queue-based model.
module tb_pc_ctrl;
  localparam logic [7:0] RV = 8'h10;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] pc, target, pc_addr;
  logic       jmp, jz, jnz, call, ret, halt, run, zero_flag;
  logic       pc_ld, halted, fault, stk_ovf, stk_unf;
  logic [2:0] sp;
  typedef enum {M_BOOT, M_RUN, M_HALT, M_FAULT} mst_t;
  mst_t       m_st;
  logic [7:0] stk[$];
  bit         m_ovf, m_unf;
  logic [7:0] m_pc, exp_addr, obs_addr;
  logic       exp_ld, obs_ld;
  int         tests = 0, fails = 0;

  pc_ctrl #(.WIDTH(8), .DEPTH(4), .RESET_VEC(RV)) dut (
    .clk(clk), .rst(rst), .pc_in(pc), .target(target), .jmp(jmp), .jz(jz), .jnz(jnz),
    .call(call), .ret(ret), .halt(halt), .run(run), .zero_flag(zero_flag),
    .pc_ld(pc_ld), .pc_addr(pc_addr), .halted(halted), .fault(fault),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf), .sp(sp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pc <= pc_ld ? pc_addr : pc + 8'd1;

  task automatic clr_in();
    {jmp, jz, jnz, call, ret, halt, run, zero_flag} = '0;
    target = 8'h00;
  endtask

  // One cycle: predict from the rules, capture DUT comb outputs, advance the model across the edge.
  task automatic step();
    #1;
    exp_ld = 1'b1;
    exp_addr = m_pc;
    case (m_st)
      M_BOOT: begin exp_addr = RV; m_st = M_RUN; end
      M_HALT: if (run) begin exp_ld = 1'b0; m_st = M_RUN; end
      M_FAULT: ;
      default:
        if (halt) m_st = M_HALT;
        else if (ret) begin
          if (stk.size() > 0) exp_addr = stk.pop_back();
          else begin m_unf = 1; m_st = M_FAULT; end
        end else if (call) begin
          if (stk.size() < 4) begin stk.push_back(8'(m_pc + 1)); exp_addr = target; end
          else begin m_ovf = 1; m_st = M_FAULT; end
        end else if (jmp) exp_addr = target;
        else if (jz) begin exp_ld = zero_flag; exp_addr = target; end
        else if (jnz) begin exp_ld = !zero_flag; exp_addr = target; end
        else exp_ld = 1'b0;
    endcase
    obs_ld = pc_ld;
    obs_addr = pc_addr;
    @(posedge clk);
    m_pc = exp_ld ? exp_addr : 8'(m_pc + 1);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b0;
    clr_in();
    m_st = M_BOOT;
    stk.delete();
    m_ovf = 0;
    m_unf = 0;
    repeat (n) @(posedge clk);
    m_pc = RV;
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clr_in();
    #1 rst = 1'b0;
    m_st = M_BOOT; stk.delete(); m_ovf = 0; m_unf = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++; if (pc_ld !== 1'b1 || pc_addr !== RV) begin fails++; $display("FAIL reset_out: ld=%b addr=%h want 1/%h", pc_ld, pc_addr, RV); end
      tests++; if (sp !== 3'd0 || halted !== 1'b0 || fault !== 1'b0) begin fails++; $display("FAIL reset_state: sp=%0d halted=%b fault=%b want 0/0/0", sp, halted, fault); end
    end
    m_pc = RV;
    rst = 1'b1;
    step();
    tests++; if (obs_ld !== 1'b1 || obs_addr !== RV || pc !== RV) begin fails++; $display("FAIL boot: ld=%b addr=%h pc=%h want 1/%h/%h", obs_ld, obs_addr, pc, RV, RV); end
    step();
    tests++; if (obs_ld !== 1'b0 || pc !== 8'h11) begin fails++; $display("FAIL boot_inc1: ld=%b pc=%h want 0/11", obs_ld, pc); end
    step();
    tests++; if (pc !== 8'h12) begin fails++; $display("FAIL boot_inc2: pc=%h want 12", pc); end
  endtask

  task automatic test_jump_branch();
    int         op  [6] = '{1, 1, 2, 2, 3, 3};
    bit         zf  [6] = '{0, 0, 0, 1, 1, 0};
    logic [7:0] tg  [6] = '{8'h05, 8'hA7, 8'h33, 8'h69, 8'h12, 8'hC4};
    logic [7:0] epc [6] = '{8'h05, 8'hA7, 8'hA8, 8'h69, 8'h6A, 8'hC4};
    for (int i = 0; i < 6; i++) begin
      clr_in();
      jmp = op[i] == 1; jz = op[i] == 2; jnz = op[i] == 3;
      zero_flag = zf[i]; target = tg[i];
      step();
      tests++; if (pc !== epc[i] || obs_ld !== exp_ld) begin fails++; $display("FAIL jump_branch[%0d]: pc=%h ld=%b want %h/%b", i, pc, obs_ld, epc[i], exp_ld); end
    end
  endtask

  task automatic test_call_ret();
    int         op  [8] = '{1, 2, 2, 3, 3, 1, 2, 3};
    logic [7:0] tg  [8] = '{8'h20, 8'h40, 8'h60, 8'h00, 8'h00, 8'hFF, 8'h80, 8'h00};
    logic [7:0] epc [8] = '{8'h20, 8'h40, 8'h60, 8'h41, 8'h21, 8'hFF, 8'h80, 8'h00};
    int         esp [8] = '{0, 1, 2, 1, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      clr_in();
      jmp = op[i] == 1; call = op[i] == 2; ret = op[i] == 3;
      target = tg[i];
      step();
      tests++; if (pc !== epc[i] || sp !== 3'(esp[i])) begin fails++; $display("FAIL call_ret[%0d]: pc=%h sp=%0d want %h/%0d", i, pc, sp, epc[i], esp[i]); end
    end
  endtask

  task automatic test_faults();
    logic [7:0] p;
    for (int i = 0; i < 4; i++) begin
      clr_in(); call = 1'b1; target = 8'($urandom);
      step();
    end
    tests++; if (sp !== 3'd4) begin fails++; $display("FAIL stack_full: sp=%0d want 4", sp); end
    p = pc;
    clr_in(); call = 1'b1; target = 8'hEE;
    step();
    tests++; if (obs_ld !== 1'b1 || obs_addr !== p || pc !== p) begin fails++; $display("FAIL ovf_hold: ld=%b addr=%h pc=%h want 1/%h/%h", obs_ld, obs_addr, pc, p, p); end
    tests++; if (stk_ovf !== 1'b1 || fault !== 1'b1 || stk_unf !== 1'b0) begin fails++; $display("FAIL ovf_flags: ovf=%b fault=%b unf=%b want 1/1/0", stk_ovf, fault, stk_unf); end
    for (int i = 0; i < 10; i++) begin
      clr_in();
      run = i[0]; jmp = 1'b1; call = i[1]; ret = i[2]; target = 8'($urandom);
      step();
      tests++; if (pc !== p || sp !== 3'd4 || fault !== 1'b1 || obs_ld !== 1'b1) begin fails++; $display("FAIL fault_frozen[%0d]: pc=%h sp=%0d fault=%b ld=%b want %h/4/1/1", i, pc, sp, fault, obs_ld, p); end
    end
    apply_reset(2);
    step();
    clr_in(); ret = 1'b1;
    step();
    tests++; if (stk_unf !== 1'b1 || fault !== 1'b1 || stk_ovf !== 1'b0 || pc !== RV) begin fails++; $display("FAIL unf: unf=%b fault=%b ovf=%b pc=%h want 1/1/0/%h", stk_unf, fault, stk_ovf, pc, RV); end
  endtask

  task automatic test_halt_run();
    apply_reset(1);
    step();
    clr_in(); call = 1'b1; target = 8'h30;
    step();
    clr_in(); halt = 1'b1;
    step();
    tests++; if (halted !== 1'b1 || pc !== 8'h30) begin fails++; $display("FAIL halt_enter: halted=%b pc=%h want 1/30", halted, pc); end
    for (int i = 0; i < 8; i++) begin
      clr_in(); jmp = 1'b1; call = i[0]; target = 8'($urandom);
      step();
      tests++; if (pc !== 8'h30 || sp !== 3'd1 || halted !== 1'b1) begin fails++; $display("FAIL halt_frozen[%0d]: pc=%h sp=%0d halted=%b want 30/1/1", i, pc, sp, halted); end
    end
    clr_in(); run = 1'b1; halt = 1'b1;
    step();
    clr_in();
    tests++; if (obs_ld !== 1'b0 || pc !== 8'h31 || halted !== 1'b0) begin fails++; $display("FAIL run_resume: ld=%b pc=%h halted=%b want 0/31/0", obs_ld, pc, halted); end
  endtask

  task automatic test_priority();
    clr_in(); halt = 1'b1; call = 1'b1; jmp = 1'b1; target = 8'h99;
    step();
    tests++; if (halted !== 1'b1 || sp !== 3'd1 || pc !== 8'h31) begin fails++; $display("FAIL prio_halt: halted=%b sp=%0d pc=%h want 1/1/31", halted, sp, pc); end
    clr_in(); run = 1'b1;
    step();
    clr_in(); ret = 1'b1; call = 1'b1; target = 8'h77;
    step();
    tests++; if (pc !== 8'h11 || sp !== 3'd0) begin fails++; $display("FAIL prio_ret: pc=%h sp=%0d want 11/0", pc, sp); end
    for (int i = 0; i < 3; i++) begin
      clr_in(); call = 1'b1; target = 8'(8'h50 + 8'h10 * i);
      step();
    end
    clr_in(); halt = 1'b1;
    step();
    tests++; if (sp !== 3'd3 || halted !== 1'b1) begin fails++; $display("FAIL pre_rst: sp=%0d halted=%b want 3/1", sp, halted); end
    rst = 1'b0;
    #1;
    tests++; if (sp !== 3'd0 || halted !== 1'b0 || pc_ld !== 1'b1 || pc_addr !== RV) begin fails++; $display("FAIL async_rst: sp=%0d halted=%b ld=%b addr=%h want 0/0/1/%h", sp, halted, pc_ld, pc_addr, RV); end
    apply_reset(2);
    step();
    tests++; if (pc !== RV || sp !== 3'd0) begin fails++; $display("FAIL rst_boot: pc=%h sp=%0d want %h/0", pc, sp, RV); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (m_st == M_FAULT && $urandom_range(0, 3) == 0) apply_reset(1);
      clr_in();
      halt = $urandom_range(0, 15) == 0;
      ret = $urandom_range(0, 4) == 0;
      call = $urandom_range(0, 3) == 0;
      jmp = $urandom_range(0, 5) == 0;
      jz = $urandom_range(0, 4) == 0;
      jnz = $urandom_range(0, 4) == 0;
      zero_flag = 1'($urandom);
      run = $urandom_range(0, 2) == 0;
      target = 8'($urandom);
      step();
      tests++; if (obs_ld !== exp_ld || (exp_ld && obs_addr !== exp_addr)) begin fails++; $display("FAIL rnd_out[%0d]: ld=%b addr=%h want %b/%h", i, obs_ld, obs_addr, exp_ld, exp_addr); end
      tests++; if (pc !== m_pc || sp !== 3'(stk.size())) begin fails++; $display("FAIL rnd_pc_sp[%0d]: pc=%h sp=%0d want %h/%0d", i, pc, sp, m_pc, stk.size()); end
      tests++; if (halted !== (m_st == M_HALT) || fault !== (m_st == M_FAULT) || stk_ovf !== m_ovf || stk_unf !== m_unf) begin fails++; $display("FAIL rnd_flags[%0d]: h=%b f=%b o=%b u=%b want %b/%b/%b/%b", i, halted, fault, stk_ovf, stk_unf, m_st == M_HALT, m_st == M_FAULT, m_ovf, m_unf); end
    end
  endtask

  initial begin
    test_reset();
    test_jump_branch();
    test_call_ret();
    test_faults();
    test_halt_run();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Next-address sequencer for the program counter (pc) of the single-cycle CPU.
- Each cycle it decides whether pc increments on its own or is loaded with a jump, branch, call or return address, or with its own value (hold).
- Owns a small hardware return-address stack for call/ret and a run/halt/fault state machine.
- Drives pc.ld and pc.addr directly; pc_in is wired back from pc.pc_out.

Parameters:
- WIDTH, 8, address width; matches pc WIDTH.
- DEPTH, 4, return-stack entries (2..16).
- RESET_VEC, 0, address loaded on the first edge after reset release.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_in  in  WIDTH  current PC value (pc.pc_out).
- target  in  WIDTH  jump/branch/call destination from the instruction.
- jmp  in  1  unconditional jump.
- jz  in  1  branch if zero_flag=1.
- jnz  in  1  branch if zero_flag=0.
- call  in  1  push pc_in+1, jump to target.
- ret  in  1  pop return address, jump to it.
- halt  in  1  enter HALT.
- run  in  1  leave HALT.
- zero_flag  in  1  ALU zero flag.
- pc_ld  out  1  load strobe to pc.
- pc_addr  out  WIDTH  load address to pc.
- halted  out  1  state==HALT.
- fault  out  1  state==FAULT.
- stk_ovf  out  1  sticky: call with stack full.
- stk_unf  out  1  sticky: ret with stack empty.
- sp  out  clog2(DEPTH+1)  stack occupancy, 0..DEPTH.

Behaviour:
- States: BOOT, RUN, HALT, FAULT. Encodings live in the package.
- Reset (rst=0, asynchronous):
  - state=BOOT, sp=0, stk_ovf=0, stk_unf=0, stack contents cleared.
  - Outputs during reset: pc_ld=1, pc_addr=RESET_VEC.
- Output timing:
  - pc_ld and pc_addr are combinational (Mealy) from state and inputs; pc captures them on the same rising edge, so there is zero added latency.
  - Registered state, sp, stack and sticky flags update on that same edge.
- BOOT:
  - pc_ld=1, pc_addr=RESET_VEC, all requests ignored.
  - Next state RUN unconditionally, so exactly one cycle after rst release.
- RUN: requests are evaluated in fixed priority halt > ret > call > jmp > jz > jnz. Only the highest-priority active request acts; the rest are ignored that cycle.
  - halt: pc_ld=1, pc_addr=pc_in; next state HALT.
  - ret with sp>0: pc_ld=1, pc_addr=stack[sp-1]; sp decrements.
  - ret with sp==0: pc_ld=1, pc_addr=pc_in; stk_unf<=1; next state FAULT.
  - call with sp<DEPTH: push (pc_in+1) mod 2^WIDTH; pc_ld=1, pc_addr=target; sp increments.
  - call with sp==DEPTH: no push; pc_ld=1, pc_addr=pc_in; stk_ovf<=1; next state FAULT.
  - jmp: pc_ld=1, pc_addr=target.
  - jz/jnz condition true: pc_ld=1, pc_addr=target.
  - jz/jnz condition false: pc_ld=0 (pc increments).
  - No request: pc_ld=0.
- HALT:
  - pc_ld=1, pc_addr=pc_in (PC frozen); all requests ignored.
  - run=1 → pc_ld=0 that cycle (PC resumes incrementing); next state RUN.
  - run and halt together in HALT → run wins.
- FAULT:
  - pc_ld=1, pc_addr=pc_in; stack, sp and flags frozen.
  - Exit only via rst. run is ignored.
- Address arithmetic:
  - Return address pc_in+1 wraps modulo 2^WIDTH: pc_in=FF pushes 00.
  - target is used unmodified.
- Stack:
  - LIFO; entry index sp-1 is the top.
  - A push and a pop never occur in the same cycle, by the priority rule above.
- sp reports occupancy: 0 is empty, DEPTH is full.
- Reset mid-sequence (including during HALT or FAULT): immediate return to BOOT outputs; stack is discarded.

Decomposition:
- Package pc_ctrl_pkg holds:
  - state encodings ST_BOOT, ST_RUN, ST_HALT, ST_FAULT;
  - request priority constants;
  - the clog2 function used to size sp.
- One sub-module, ret_stack: parameterised LIFO with push, pop, din, dout, sp, full and empty outputs, and asynchronous active-low clear.
- pc_ctrl contains the FSM, the next-address mux and the sticky flags.

Test Plan:
- Reset/boot: RESET_VEC=10, rst low 3 cycles, then high → pc_ld=1 and addr=10 during reset and the first cycle; pc reads 10, then 11 and 12 with pc_ld=0.
- Jump and branch: at pc=05 jmp with target=A7 → pc=A7 next cycle. jz with zero_flag=0 → increment; jz with zero_flag=1, target=69 → pc=69. jnz mirrors both cases.
- Call/ret nesting, DEPTH=4:
  - call at 20 (target 40), then call at 40 (target 60) → sp=2.
  - ret → pc=41, sp=1; ret → pc=21, sp=0.
  - Wrap case: call at FF → stack holds 00.
- Stack faults:
  - 5th call with sp=4 → stk_ovf=1, fault=1, PC held for 10 cycles, run ignored.
  - After reset, ret with sp=0 → stk_unf=1, fault=1.
- Halt/run: halt at pc=30 → halted=1, pc stays 30 for 8 cycles under jmp/call stimulus, sp unchanged. run pulse → pc 31 on the next edge.
- Priority and mid-op reset:
  - halt+call+jmp together → HALT, no push.
  - ret+call together with sp=1 → pop only.
  - rst asserted while halted, with sp=3 → sp=0, state BOOT, pc=RESET_VEC.
